// File: rtl/traffic_pkg.sv
// Shared light encodings, direction codes and phase state for the intersection scheduler.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_W = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_E = 2'd3;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } phase_state_t;

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Round-robin approach selector: first requesting approach after ptr, wrapping.
module traffic_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant_dir,
  output logic       any_req
);

  logic [1:0] cand;

  // Scan farthest-first so the nearest requester after ptr is the last to land.
  always_comb begin
    grant_dir = ptr;
    cand      = ptr;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) grant_dir = cand;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-way phase scheduler with min/max green and gap-out.
// Optional emergency preemption compiled in with EMERG_PREEMPT_EN.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN    = 4,
  parameter int unsigned MAX_GREEN    = 8,
  parameter int unsigned YELLOW_TIME  = 3,
  parameter int unsigned ALL_RED_TIME = 2,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sense,
`ifdef EMERG_PREEMPT_EN
  input  logic [3:0] emerg_req,
`endif
  output logic [2:0] north_light,
  output logic [2:0] west_light,
  output logic [2:0] south_light,
  output logic [2:0] east_light,
  output logic [1:0] active_dir,
  output logic       phase_start
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  phase_state_t     state, state_nxt;
  logic [1:0]       dir, dir_nxt, ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       dmd, dmd_nxt, other;
  logic [1:0]       rr_dir;
  logic             rr_any;
  logic             emerg_any;
  logic [1:0]       emerg_dir;
  logic [2:0]       lamp;

  traffic_rr_pick u_rr_pick (
    .req       (dmd),
    .ptr       (ptr),
    .grant_dir (rr_dir),
    .any_req   (rr_any)
  );

`ifdef EMERG_PREEMPT_EN
  // Fixed-priority emergency target, N highest.
  always_comb begin
    emerg_any = |emerg_req;
    casez (emerg_req)
      4'b???1: emerg_dir = DIR_N;
      4'b??10: emerg_dir = DIR_W;
      4'b?100: emerg_dir = DIR_S;
      default: emerg_dir = DIR_E;
    endcase
  end
`else
  assign emerg_any = 1'b0;
  assign emerg_dir = DIR_N;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_ALL_RED;
      dir         <= DIR_N;
      ptr         <= DIR_E;
      cnt         <= '0;
      dmd         <= '0;
      phase_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      dir         <= dir_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      dmd         <= dmd_nxt;
      phase_start <= (state_nxt == ST_GREEN) && (state != ST_GREEN);
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    ptr_nxt   = ptr;
    other     = dmd & ~dir_onehot(dir);
    dmd_nxt   = dmd | sense;
    if (state == ST_GREEN) dmd_nxt = dmd_nxt & ~dir_onehot(dir);

    case (state)
      ST_ALL_RED: begin
        if (cnt >= CNT_W'(ALL_RED_TIME - 1)) begin
          if (emerg_any) begin
            state_nxt = ST_GREEN;
            dir_nxt   = emerg_dir;
            ptr_nxt   = emerg_dir;
          end else if (rr_any) begin
            state_nxt = ST_GREEN;
            dir_nxt   = rr_dir;
            ptr_nxt   = rr_dir;
          end
        end
      end
      ST_GREEN: begin
        if (emerg_any) begin
          if (emerg_dir != dir) state_nxt = ST_YELLOW;
        end else if ((other != 4'b0000) &&
                     (((cnt >= CNT_W'(MIN_GREEN - 1)) && !sense[dir]) ||
                      (cnt >= CNT_W'(MAX_GREEN - 1)))) begin
          state_nxt = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (cnt >= CNT_W'(YELLOW_TIME - 1)) state_nxt = ST_ALL_RED;
      end
      default: state_nxt = ST_ALL_RED;
    endcase

    if (state_nxt != state)  cnt_nxt = '0;
    else if (cnt == CNT_MAX) cnt_nxt = cnt;
    else                     cnt_nxt = cnt + CNT_W'(1);
  end

  // Lamp decode from registered state and direction.
  always_comb begin
    north_light = LIGHT_RED;
    west_light  = LIGHT_RED;
    south_light = LIGHT_RED;
    east_light  = LIGHT_RED;
    active_dir  = DIR_N;
    lamp        = (state == ST_GREEN) ? LIGHT_GREEN : LIGHT_YELLOW;
    if (state != ST_ALL_RED) begin
      active_dir = dir;
      case (dir)
        DIR_N:   north_light = lamp;
        DIR_W:   west_light  = lamp;
        DIR_S:   south_light = lamp;
        default: east_light  = lamp;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench: phase-level reference model plus directed timing checks and random demand.
module tb_traffic_phase_scheduler;

  localparam int MIN_GREEN    = 4;
  localparam int MAX_GREEN    = 8;
  localparam int YELLOW_TIME  = 3;
  localparam int ALL_RED_TIME = 2;
  localparam int PH_AR = 0, PH_G = 1, PH_Y = 2;

  logic       clk, reset;
  logic [3:0] sense;
  logic [2:0] north_light, west_light, south_light, east_light;
  logic [1:0] active_dir;
  logic       phase_start;

  int n_checks, n_fail;
  bit chk_en;

  traffic_phase_scheduler #(
    .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW_TIME(YELLOW_TIME),
    .ALL_RED_TIME(ALL_RED_TIME), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .sense(sense),
    .north_light(north_light), .west_light(west_light),
    .south_light(south_light), .east_light(east_light),
    .active_dir(active_dir), .phase_start(phase_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] get_light(input int i);
    case (i)
      0:       return north_light;
      1:       return west_light;
      2:       return south_light;
      default: return east_light;
    endcase
  endfunction

  // Reference model: phase, cycles spent in phase, served approach, latched demand.
  int         m_ph, m_t, m_dir, m_ptr;
  logic [3:0] m_dmd;
  bit         m_ps;
  int         nph, ndir, nptr, elapsed, cand;
  logic [3:0] ndmd;
  bit         found, waiting;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph = PH_AR; m_t = 0; m_dir = 0; m_ptr = 3; m_dmd = 4'b0000; m_ps = 1'b0;
    end else begin
      nph = m_ph; ndir = m_dir; nptr = m_ptr;
      ndmd = m_dmd | sense;
      if (m_ph == PH_G) ndmd[m_dir] = 1'b0;
      elapsed = m_t + 1;
      if (m_ph == PH_AR) begin
        if (elapsed >= ALL_RED_TIME && m_dmd != 4'b0000) begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            cand = (m_ptr + k) % 4;
            if (!found && m_dmd[cand]) begin ndir = cand; found = 1'b1; end
          end
          nph = PH_G; nptr = ndir;
        end
      end else if (m_ph == PH_G) begin
        waiting = (m_dmd & ~(4'b0001 << m_dir)) != 4'b0000;
        if (waiting && ((elapsed >= MIN_GREEN && !sense[m_dir]) || elapsed >= MAX_GREEN))
          nph = PH_Y;
      end else if (elapsed >= YELLOW_TIME) begin
        nph = PH_AR;
      end
      m_ps  = (nph == PH_G) && (m_ph != PH_G);
      m_t   = (nph == m_ph) ? elapsed : 0;
      m_ph  = nph; m_dir = ndir; m_ptr = nptr; m_dmd = ndmd;
    end
  end

  function automatic logic [2:0] exp_light(input int i);
    if (m_ph == PH_AR || i != m_dir) return 3'b100;
    return (m_ph == PH_G) ? 3'b001 : 3'b010;
  endfunction

  // Per-cycle comparison against the model.
  int nonred;
  always @(negedge clk) begin
    if (chk_en) begin
      nonred = 0;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("light%0d", i), 32'(get_light(i)), 32'(exp_light(i)));
        if (get_light(i) !== 3'b100) nonred++;
      end
      check("active_dir", 32'(active_dir), (m_ph == PH_AR) ? 0 : m_dir);
      check("phase_start", 32'(phase_start), 32'(m_ps));
      check("exclusive_nonred", (nonred > 1) ? 1 : 0, 0);
    end
  end

  task automatic wait_for(input int i, input logic [2:0] v, output int n);
    n = 0;
    while (get_light(i) !== v && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("wait_bound", 32'(get_light(i)), 32'(v));
  endtask

  task automatic run_len(input int i, input logic [2:0] v, output int n);
    n = 0;
    while (get_light(i) === v && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    sense = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  int n, mode;
  logic [3:0] hold;

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    reset = 1'b0; sense = 4'b0000;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    reset = 1'b1;

    // No demand: all red, no phase start.
    repeat (20) begin
      @(negedge clk);
      check("idle_north", 32'(north_light), 32'(3'b100));
      check("idle_ps", 32'(phase_start), 0);
    end
    check("idle_dir", 32'(active_dir), 0);

    // Single north pulse: two all-red cycles, then north rests in green.
    do_reset();
    sense = 4'b0001;
    @(negedge clk);
    check("n_pulse_red", 32'(north_light), 32'(3'b100));
    sense = 4'b0000;
    @(negedge clk);
    check("n_pulse_green", 32'(north_light), 32'(3'b001));
    check("n_pulse_ps", 32'(phase_start), 1);
    repeat (22) @(negedge clk);
    check("n_rest_green", 32'(north_light), 32'(3'b001));

    // North held, west pulsed: max-out then west.
    do_reset();
    sense = 4'b0001;
    wait_for(0, 3'b001, n);
    check("maxout_grant_lat", n, 2);
    sense = 4'b0011;
    @(negedge clk);
    sense = 4'b0001;
    run_len(0, 3'b001, n);
    check("maxout_green_len", n + 1, 8);
    run_len(0, 3'b010, n);
    check("maxout_yellow_len", n, 3);
    run_len(1, 3'b100, n);
    check("maxout_allred_len", n, 2);
    check("maxout_west_dir", 32'(active_dir), 1);

    // Gap-out at minimum green.
    do_reset();
    sense = 4'b0011;
    @(negedge clk);
    sense = 4'b0000;
    wait_for(0, 3'b001, n);
    run_len(0, 3'b001, n);
    check("gapout_min_len", n, 4);

    // Late west demand during resting north green.
    do_reset();
    sense = 4'b0001;
    wait_for(0, 3'b001, n);
    repeat (5) @(negedge clk);
    sense = 4'b0010;
    @(negedge clk);
    sense = 4'b0000;
    run_len(0, 3'b001, n);
    check("late_demand_len", n + 6, 7);

    // Full demand: N, W, S, E, N each maxed out.
    do_reset();
    sense = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      wait_for(p % 4, 3'b001, n);
      check("rr_dir", 32'(active_dir), p % 4);
      run_len(p % 4, 3'b001, n);
      check("rr_green_len", n, 8);
    end

    // Asynchronous reset during north yellow.
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) check("async_rst_light", 32'(get_light(i)), 32'(3'b100));
    check("async_rst_dir", 32'(active_dir), 0);
    @(negedge clk);
    reset = 1'b1;
    sense = 4'b0100;
    wait_for(2, 3'b001, n);
    check("south_first_lat", n, 2);
    check("south_first_dir", 32'(active_dir), 2);
    sense = 4'b0000;

    // Random demand with occasional resets.
    mode = 0; hold = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        mode = int'($urandom_range(0, 2));
        hold = 4'($urandom);
      end
      case (mode)
        0:       sense = 4'($urandom) & 4'($urandom) & 4'($urandom);
        1:       sense = hold;
        default: sense = 4'($urandom);
      endcase
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    sense = 4'b0000;
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
